// File: rtl/sub_accum_if.sv
// Common fixed-point parameter bundle: shared clock, reset and data width
// for the subtractor/accumulator pipeline.
interface fixedp #(
  parameter int WIDTH = 16
) (
  input logic clk,
  input logic reset
);
  modport dut (input clk, input reset);
endinterface

// File: rtl/sub_accum.sv
// Streaming signed accumulator: saturating per-vector sum of difference
// words, one result (sum, count, flags) per vector.
module sub_accum #(
  parameter int WIDTH  = 16,
  parameter int MAXLEN = 1024,
  localparam int CW    = $clog2(MAXLEN + 1)
) (
  fixedp.dut               g,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_sum,
  output logic [CW-1:0]    out_count,
  output logic             out_sat,
  output logic             out_err
);

  typedef enum logic {IDLE, ACC} state_t;

  localparam logic [CW-1:0]    MAXC   = CW'(MAXLEN);
  localparam logic [WIDTH-1:0] MAXPOS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINNEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             sat_s;

  logic [WIDTH-1:0] base;
  logic [WIDTH:0]   s;
  logic [WIDTH-1:0] res;
  logic             bsat;
  logic [CW-1:0]    cnt_n;
  logic             term;

  always_comb begin
    base  = (state == IDLE) ? '0 : acc;
    s     = {base[WIDTH-1], base} + {in_data[WIDTH-1], in_data};
    res   = s[WIDTH-1:0];
    bsat  = 1'b0;
    // Top two bits of the WIDTH+1 sum disagree only on overflow.
    if (!s[WIDTH] && s[WIDTH-1]) begin
      res  = MAXPOS;
      bsat = 1'b1;
    end else if (s[WIDTH] && !s[WIDTH-1]) begin
      res  = MINNEG;
      bsat = 1'b1;
    end
    cnt_n = cnt + 1'b1;
    term  = in_last || (cnt_n == MAXC);
  end

  always_ff @(posedge g.clk) begin
    if (g.reset) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      sat_s     <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        if (term) begin
          out_valid <= 1'b1;
          out_sum   <= res;
          out_count <= cnt_n;
          out_sat   <= sat_s | bsat;
          out_err   <= ~in_last;
          state     <= IDLE;
          acc       <= '0;
          cnt       <= '0;
          sat_s     <= 1'b0;
        end else begin
          state <= ACC;
          acc   <= res;
          cnt   <= cnt_n;
          sat_s <= sat_s | bsat;
        end
      end
    end
  end

endmodule

// File: tb/tb_sub_accum.sv
// Randomized scoreboard bench for sub_accum (WIDTH=16, MAXLEN=8) against
// an integer reference model of the vector sum rules.
module tb_sub_accum;

  localparam int W  = 16;
  localparam int ML = 8;
  localparam int CW = $clog2(ML + 1);

  typedef struct {
    logic [W-1:0]  sum;
    logic [CW-1:0] count;
    logic          sat;
    logic          err;
  } res_t;

  logic          clk = 0;
  logic          reset = 1;
  logic          in_valid = 0;
  logic [W-1:0]  in_data = '0;
  logic          in_last = 0;
  logic          out_valid;
  logic [W-1:0]  out_sum;
  logic [CW-1:0] out_count;
  logic          out_sat;
  logic          out_err;

  fixedp #(.WIDTH(W)) g (.clk(clk), .reset(reset));

  sub_accum #(.WIDTH(W), .MAXLEN(ML)) dut (
    .g(g),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_sum(out_sum),
    .out_count(out_count),
    .out_sat(out_sat),
    .out_err(out_err)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   npush = 0;
  int   npop = 0;
  bit   mon_on = 0;
  res_t q[$];
  res_t hold;

  // Reference model state: open vector sum, beat count, sticky saturation.
  int m_acc = 0;
  int m_cnt = 0;
  bit m_sat = 0;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    m_acc = 0;
    m_cnt = 0;
    m_sat = 0;
  endfunction

  function automatic void model_beat(logic [W-1:0] d, bit last);
    int   v;
    bit   bs;
    res_t r;
    v  = m_acc + int'($signed(d));
    bs = 0;
    if (v > 32767) begin
      v  = 32767;
      bs = 1;
    end else if (v < -32768) begin
      v  = -32768;
      bs = 1;
    end
    m_cnt++;
    m_sat = m_sat | bs;
    m_acc = v;
    if (last || m_cnt == ML) begin
      r.sum   = W'(v);
      r.count = CW'(m_cnt);
      r.sat   = m_sat;
      r.err   = !last;
      q.push_back(r);
      npush++;
      model_clear();
    end
  endfunction

  task automatic cyc(bit v, logic [W-1:0] d, bit l);
    in_valid = v;
    in_data  = d;
    in_last  = l;
    if (v) model_beat(d, l);
    @(posedge clk);
    #1;
  endtask

  task automatic rst(bit v, logic [W-1:0] d, bit l);
    reset    = 1;
    in_valid = v;
    in_data  = d;
    in_last  = l;
    model_clear();
    @(posedge clk);
    #1;
    reset = 0;
    hold  = '{sum: '0, count: '0, sat: 0, err: 0};
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, '0, 0);
  endtask

  // Monitor: pops on each out_valid, otherwise checks the held result.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (out_valid) begin
          if (q.size() == 0) begin
            chk("spurious_out_valid", 1, 0);
          end else begin
            e = q.pop_front();
            npop++;
            chk("sum", int'($signed(out_sum)), int'($signed(e.sum)));
            chk("count", int'(out_count), int'(e.count));
            chk("sat", int'(out_sat), int'(e.sat));
            chk("err", int'(out_err), int'(e.err));
            hold = e;
          end
        end else begin
          chk("hold_sum", int'(out_sum), int'(hold.sum));
          chk("hold_count", int'(out_count), int'(hold.count));
          chk("hold_flags", int'({out_sat, out_err}),
              int'({hold.sat, hold.err}));
        end
      end
    end
  end

  initial begin
    logic [W-1:0] d;
    bit v, l;
    @(posedge clk);
    #1;
    rst(0, '0, 0);
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_sum", int'(out_sum), 0);
    chk("reset_count", int'(out_count), 0);
    chk("reset_flags", int'({out_sat, out_err}), 0);
    mon_on = 1;

    cyc(1, 16'd3, 0);
    cyc(1, -16'sd5, 0);
    cyc(1, 16'd10, 1);
    idle(3);

    cyc(1, 16'd30000, 0);
    cyc(1, 16'd30000, 1);
    cyc(1, 16'd30000, 0);
    cyc(1, 16'd30000, 0);
    cyc(1, -16'sd10000, 1);
    cyc(1, 16'h8000, 0);
    cyc(1, 16'hffff, 1);
    idle(2);

    cyc(1, 16'd1, 0);
    cyc(1, 16'd2, 1);
    cyc(1, 16'd7, 1);
    idle(2);

    for (int i = 0; i < 8; i++) cyc(1, 16'd1, 0);
    cyc(1, 16'd4, 1);
    idle(2);

    cyc(1, 16'd5, 0);
    idle(3);
    cyc(0, 16'd99, 1);
    cyc(1, 16'd6, 1);
    idle(2);

    cyc(1, 16'd100, 0);
    cyc(1, 16'd200, 0);
    rst(0, '0, 0);
    cyc(1, 16'd1, 1);
    idle(2);
    cyc(1, 16'd50, 0);
    rst(1, 16'd60, 1);
    idle(2);

    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 2) == 0) d = W'($urandom);
      else d = W'($urandom_range(0, 200) - 100);
      if ($urandom_range(0, 99) == 0) rst(v, d, l);
      else cyc(v, d, l);
    end
    idle(4);

    chk("queue_drained", q.size(), 0);
    chk("result_count", npop, npush);
    mon_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
